io_button_reader: RTL and testbench

- Input-side counterpart to the LED driver logic: conditions the raw Io-board push buttons into clean, single-clock-domain control signals for the rest of the fabric.
- Each button channel provides:
  - 2-flop synchroniser
  - counter-based debouncer
  - press/release edge pulses
  - hold-to-repeat state machine
- Sits directly behind the top-level button pins; feeds counters, mode selects and LED display logic.

---
 rtl/io_button_pkg.sv | 19 +
 rtl/io_button_if.sv | 21 ++
 rtl/io_button_reader_channel.sv | 154 +++++++++++++++
 rtl/io_button_reader.sv | 42 ++++
 tb/tb_io_button_reader.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/io_button_pkg.sv
// Shared definitions for the button reader: repeat FSM encoding and counter sizing helpers.
package io_button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Bits needed to hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_button_if.sv
// Button pin inputs and conditioned per-button event outputs, one bit per channel.
interface io_button_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] io_button;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;
    logic [NUM_BTN-1:0] btn_event;

    modport master (
        input  io_button,
        output btn_level, btn_press, btn_release, btn_repeat, btn_event
    );

    modport slave (
        output io_button,
        input  btn_level, btn_press, btn_release, btn_repeat, btn_event
    );
endinterface

// File: rtl/io_button_reader_channel.sv
// One button: 2-flop sync, counter debouncer, press/release pulses and hold-to-repeat FSM.
// Input is already active-high; the top handles pin polarity.
//
//   state  | meaning
//   IDLE   | button released, no repeat timing
//   HELD   | pressed, waiting out the initial hold delay
//   REPEAT | pressed past hold delay, pulsing every repeat period
module button_channel
    import io_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic btn_reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic event_o
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int RP_W = cnt_width(max_of(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            accept, rise, fall;

    rep_state_e      state_q, state_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_fire;

    logic press_q, press_d;
    logic release_q, release_d;
    logic repeat_q, repeat_d;
    logic event_q, event_d;

    always_ff @(posedge clk) begin
        if (btn_reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Counter clears whenever the synced input agrees with the accepted level.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        accept   = 1'b0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = s2_q;
                accept  = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign rise = accept & s2_q;
    assign fall = accept & ~s2_q;

    always_ff @(posedge clk) begin
        if (btn_reset) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // A release wins over a terminal count in the same cycle.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                rep_cnt_d = '0;
                if (rise) state_d = HELD;
            end
            HELD: begin
                if (fall) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == HOLD_LAST) begin
                    state_d   = REPEAT;
                    rep_cnt_d = '0;
                    rep_fire  = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + RP_W'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = '0;
                    rep_fire  = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + RP_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        press_d   = rise;
        release_d = fall;
        repeat_d  = rep_fire;
        event_d   = rise | rep_fire;
    end

    always_ff @(posedge clk) begin
        if (btn_reset) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            event_q   <= event_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;
    assign event_o   = event_q;

endmodule

// File: rtl/io_button_reader.sv
// Io-board button front end: applies pin polarity and runs one independent channel per button.
module io_button_reader #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int BTN_ACTIVE_HIGH = 1
) (
    input  logic        clk,
    input  logic        btn_reset,
    io_button_if.master bus
);

    logic [NUM_BTN-1:0] pin_act;
    logic [NUM_BTN-1:0] level_w, press_w, release_w, repeat_w, event_w;

    assign pin_act = (BTN_ACTIVE_HIGH != 0) ? bus.io_button : ~bus.io_button;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .clk      (clk),
            .btn_reset(btn_reset),
            .btn_i    (pin_act[g]),
            .level_o  (level_w[g]),
            .press_o  (press_w[g]),
            .release_o(release_w[g]),
            .repeat_o (repeat_w[g]),
            .event_o  (event_w[g])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_repeat  = repeat_w;
    assign bus.btn_event   = event_w;

endmodule

// File: tb/tb_io_button_reader.sv
// Bench for io_button_reader: active-high and active-low instances driven together,
// outputs checked every cycle against a window/timestamp reference model via queues.
module tb_io_button_reader;

    localparam int NB   = 2;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    typedef struct {
        int         cyc;
        logic [1:0] lvl, prs, rel, rep, evt;
    } rec_t;

    logic clk = 1'b0;
    logic btn_reset;
    always #5 clk = ~clk;

    io_button_if #(.NUM_BTN(NB)) if_a ();
    io_button_if #(.NUM_BTN(NB)) if_b ();

    io_button_reader #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .BTN_ACTIVE_HIGH(1)
    ) dut_a (.clk(clk), .btn_reset(btn_reset), .bus(if_a.master));

    io_button_reader #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .BTN_ACTIVE_HIGH(0)
    ) dut_b (.clk(clk), .btn_reset(btn_reset), .bus(if_b.master));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    rec_t qa[$];
    rec_t qb[$];

    // Reference: pressed-level history, level flips when the last DB synced samples all differ.
    logic [DB+1:0] hist   [2][NB];
    logic          lvl_m  [2][NB];
    int            since_m[2][NB];

    task automatic model_step(input int d, input int c, input logic eff, input logic r,
                              output logic lv, output logic pr, output logic rl, output logic rp);
        logic prev, all_diff;
        if (r) begin
            hist[d][c]    = '0;
            lvl_m[d][c]   = 1'b0;
            since_m[d][c] = 0;
            lv = 1'b0; pr = 1'b0; rl = 1'b0; rp = 1'b0;
            return;
        end
        hist[d][c] = {hist[d][c][DB:0], eff};
        all_diff = 1'b1;
        for (int i = 2; i <= DB + 1; i++)
            if (hist[d][c][i] == lvl_m[d][c]) all_diff = 1'b0;
        prev = lvl_m[d][c];
        if (all_diff) lvl_m[d][c] = ~lvl_m[d][c];
        lv = lvl_m[d][c];
        pr = ~prev & lv;
        rl = prev & ~lv;
        if (pr) since_m[d][c] = 0;
        else if (lv) since_m[d][c] = since_m[d][c] + 1;
        rp = lv && !pr && since_m[d][c] >= HOLD && ((since_m[d][c] - HOLD) % REP) == 0;
    endtask

    task automatic drive(input logic r, input logic [1:0] pa, input logic [1:0] pb);
        rec_t ea, eb;
        logic lv, pr, rl, rp;
        btn_reset      = r;
        if_a.io_button = pa;
        if_b.io_button = pb;
        cyc++;
        ea.cyc = cyc;
        eb.cyc = cyc;
        for (int c = 0; c < NB; c++) begin
            model_step(0, c, pa[c], r, lv, pr, rl, rp);
            ea.lvl[c] = lv; ea.prs[c] = pr; ea.rel[c] = rl; ea.rep[c] = rp;
            model_step(1, c, ~pb[c], r, lv, pr, rl, rp);
            eb.lvl[c] = lv; eb.prs[c] = pr; eb.rel[c] = rl; eb.rep[c] = rp;
        end
        ea.evt = ea.prs | ea.rep;
        eb.evt = eb.prs | eb.rep;
        qa.push_back(ea);
        qb.push_back(eb);
        @(negedge clk);
    endtask

    task automatic check(input int d, input rec_t e, input logic [9:0] act);
        logic [9:0] exp_v;
        exp_v = {e.lvl, e.prs, e.rel, e.rep, e.evt};
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL outputs dut%0d edge %0d {level,press,release,repeat,event}: got %b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
                     d, e.cyc, act[9:8], act[7:6], act[5:4], act[3:2], act[1:0],
                     exp_v[9:8], exp_v[7:6], exp_v[5:4], exp_v[3:2], exp_v[1:0]);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0)
            check(0, qa.pop_front(), {if_a.btn_level, if_a.btn_press, if_a.btn_release,
                                      if_a.btn_repeat, if_a.btn_event});
        if (qb.size() > 0)
            check(1, qb.pop_front(), {if_b.btn_level, if_b.btn_press, if_b.btn_release,
                                      if_b.btn_repeat, if_b.btn_event});
    end

    int       rem[4];
    logic     val[4];
    int       rst_left;
    logic [1:0] pa, pb;

    initial begin
        // Reset and clean press held into repeat, released so debounce lands on a repeat terminal.
        repeat (3) drive(1'b1, 2'b00, 2'b11);
        repeat (16) drive(1'b0, 2'b01, 2'b11);
        repeat (20) drive(1'b0, 2'b00, 2'b11);
        // Short glitch that must never be accepted.
        repeat (3)  drive(1'b0, 2'b01, 2'b11);
        repeat (10) drive(1'b0, 2'b00, 2'b11);
        // Long hold with many repeats, then release.
        repeat (50) drive(1'b0, 2'b01, 2'b11);
        repeat (15) drive(1'b0, 2'b00, 2'b11);
        // Reset in the middle of REPEAT with the pin still held.
        repeat (25) drive(1'b0, 2'b01, 2'b11);
        repeat (2)  drive(1'b1, 2'b01, 2'b11);
        repeat (20) drive(1'b0, 2'b01, 2'b11);
        repeat (15) drive(1'b0, 2'b00, 2'b11);
        // Simultaneous press on both active-low pins and both active-high pins.
        repeat (20) drive(1'b0, 2'b11, 2'b00);
        repeat (15) drive(1'b0, 2'b00, 2'b11);

        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            val[i] = (i >= 2);
        end
        rst_left = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    val[i] = ~val[i];
                    rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 45);
                end
                rem[i]--;
            end
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            pa = {val[1], val[0]};
            pb = {val[3], val[2]};
            drive(rst_left != 0, pa, pb);
            if (rst_left != 0) rst_left--;
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expected records left unchecked, required 0/0",
                     qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
